// File: rtl/nn_pkg.sv
// Shared definitions for the fully-connected layer glue logic.
package nn_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   // Counter must hold the value n, so it needs clog2(n+1) bits.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/layer_out_serializer.sv
// Captures one layer's parallel neuron outputs and replays them one word per
// cycle as the next layer's myinput/myinputValid stream.
module layer_out_serializer
   import nn_pkg::*;
#(
   parameter int numNeuron = 30,
   parameter int dataWidth = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [numNeuron*dataWidth-1:0] neuron_out,
   input  logic [numNeuron-1:0]           neuron_valid,
   output logic [dataWidth-1:0]           out_data,
   output logic                           out_valid,
   output logic                           frame_done,
   output logic                           busy,
   output logic                           overrun,
   output logic                           misalign
);

   localparam int CW = cnt_width(numNeuron);
   localparam int FW = numNeuron * dataWidth;
   localparam logic [CW-1:0] LAST = CW'(numNeuron);

   state_e                 state_q, state_d;
   logic [CW-1:0]          count_q, count_d;
   logic [FW-1:0]          shreg_q, shreg_d;
   logic [dataWidth-1:0]   data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   done_q, done_d;
   logic                   ovr_q, ovr_d;
   logic                   mis_q, mis_d;

   logic cap, at_last, load;

   assign cap     = neuron_valid[0];
   assign at_last = (state_q == SHIFT) && (count_q == LAST);
   // A new frame is accepted when idle or while the final word is on the bus.
   assign load    = cap && ((state_q == IDLE) || at_last);

   always_comb begin
      // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
      state_d = state_q;
      count_d = count_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      mis_d   = mis_q | (cap & ~(&neuron_valid));

      if (load) begin
         data_d  = neuron_out[dataWidth-1:0];
         shreg_d = neuron_out >> dataWidth;
         valid_d = 1'b1;
         count_d = CW'(1);
         state_d = SHIFT;
      end else if (state_q == SHIFT) begin
         ovr_d = ovr_q | cap;
         if (at_last) begin
            data_d  = '0;
            valid_d = 1'b0;
            count_d = '0;
            state_d = IDLE;
         end else begin
            data_d  = shreg_q[dataWidth-1:0];
            shreg_d = shreg_q >> dataWidth;
            count_d = count_q + CW'(1);
         end
      end

      // count equals numNeuron exactly while the last word is presented.
      done_d = (state_d == SHIFT) && (count_d == LAST);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
         mis_q   <= mis_d;
      end
   end

   assign out_data   = data_q;
   assign out_valid  = valid_q;
   assign frame_done = done_q;
   assign busy       = (state_q == SHIFT);
   assign overrun    = ovr_q;
   assign misalign   = mis_q;

endmodule

// File: tb/tb_layer_out_serializer.sv
// Randomized scoreboard bench: a timeline model predicts which frames are
// accepted and when each word appears; a negedge monitor compares.
module tb_layer_out_serializer;

   localparam int N = 4;
   localparam int W = 16;
   localparam int NEVER = 32'h7fff_ffff;

   typedef struct {
      logic [W-1:0] d;
      int           c;
      bit           last;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N*W-1:0]   neuron_out = '0;
   logic [N-1:0]     neuron_valid = '0;
   logic [W-1:0]     out_data;
   logic             out_valid, frame_done, busy, overrun, misalign;

   layer_out_serializer #(.numNeuron(N), .dataWidth(W)) dut (
      .clk(clk), .rst(rst), .neuron_out(neuron_out), .neuron_valid(neuron_valid),
      .out_data(out_data), .out_valid(out_valid), .frame_done(frame_done),
      .busy(busy), .overrun(overrun), .misalign(misalign)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   exp_t q[$];
   int   last_cyc = -1;
   int   ovr_from = NEVER;
   int   mis_from = NEVER;
   int   n_chk = 0;
   int   n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Cap driven in cycle k is accepted when no frame is running or the running
   // frame shows its last word in cycle k; its words then occupy k+1..k+N.
   task automatic drive(input logic [N*W-1:0] d, input logic [N-1:0] v);
      @(posedge clk);
      #1;
      neuron_out   = d;
      neuron_valid = v;
      if (v[0]) begin
         if (v != {N{1'b1}} && mis_from == NEVER) mis_from = cyc + 1;
         if (cyc >= last_cyc) begin
            for (int i = 0; i < N; i++)
               q.push_back('{d: d[i*W +: W], c: cyc + 1 + i, last: (i == N - 1)});
            last_cyc = cyc + N;
         end else if (ovr_from == NEVER) begin
            ovr_from = cyc + 1;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         drive({$urandom, $urandom, $urandom, $urandom} & {N*W{1'b1}},
               N'($urandom) & ~N'(1));
   endtask

   // Reset lands mid-cycle; outputs must clear before any clock edge.
   task automatic do_reset();
      @(posedge clk);
      #3;
      rst          = 1'b1;
      neuron_valid = '0;
      q.delete();
      last_cyc = -1;
      ovr_from = NEVER;
      mis_from = NEVER;
      #1;
      check("rst_out_data",   32'(out_data),   32'd0);
      check("rst_out_valid",  32'(out_valid),  32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_busy",       32'(busy),       32'd0);
      check("rst_overrun",    32'(overrun),    32'd0);
      check("rst_misalign",   32'(misalign),   32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      bit   exp_v;
      exp_t e;
      while (q.size() > 0 && q[0].c < cyc) begin
         check("missed_word_cycle", 32'(cyc), 32'(q[0].c));
         void'(q.pop_front());
      end
      exp_v = (q.size() > 0) && (q[0].c == cyc);
      check("out_valid", 32'(out_valid), 32'(exp_v));
      check("busy",      32'(busy),      32'(exp_v));
      if (exp_v) begin
         e = q.pop_front();
         check("out_data",   32'(out_data),   32'(e.d));
         check("frame_done", 32'(frame_done), 32'(e.last));
      end else begin
         check("idle_data", 32'(out_data),   32'd0);
         check("idle_done", 32'(frame_done), 32'd0);
      end
      check("overrun",  32'(overrun),  32'(cyc >= ovr_from));
      check("misalign", 32'(misalign), 32'(cyc >= mis_from));
   end

   initial begin
      do_reset();
      idle(3);

      // Single frame, then a back-to-back frame on the last-word cycle.
      drive({16'h0004, 16'h0003, 16'h0002, 16'h0001}, 4'hF);
      idle(N - 1);
      drive({16'h000D, 16'h000C, 16'h000B, 16'h000A}, 4'hF);
      idle(N + 2);

      // Cap mid-frame is dropped; original words still emerge.
      drive({16'h0104, 16'h0103, 16'h0102, 16'h0101}, 4'hF);
      idle(1);
      drive({16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D}, 4'hF);
      idle(N + 3);

      // Reset in the middle of a frame, then a clean frame.
      drive({16'h0204, 16'h0203, 16'h0202, 16'h0201}, 4'hF);
      idle(1);
      do_reset();
      idle(2);
      drive({16'h0304, 16'h0303, 16'h0302, 16'h0301}, 4'hF);
      idle(N + 2);

      // Misaligned valids: frame still emitted, flag sticky.
      drive({16'h0404, 16'h0403, 16'h0402, 16'h0401}, 4'b0111);
      idle(N + 2);
      do_reset();

      for (int i = 0; i < 400; i++) begin
         logic [N*W-1:0] d;
         logic [N-1:0]   v;
         d = {$urandom, $urandom, $urandom, $urandom} & {N*W{1'b1}};
         if ($urandom_range(0, 2) == 0)
            v = ($urandom_range(0, 7) == 0) ? (N'($urandom) | N'(1)) : {N{1'b1}};
         else
            v = N'($urandom) & ~N'(1);
         drive(d, v);
         if (i == 200) do_reset();
      end

      idle(N + 3);
      check("queue_drained", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/layer_out_serializer.md
Name: layer_out_serializer

Overview:
- Sits between two fully-connected layers.
- Captures the parallel activation words that all neurons of one layer present together on their out/outvalid pins.
- Replays those words one per cycle as a contiguous input stream, in the form the next layer's neurons take on myinput/myinputValid.
- Holds the captured frame in its own register, so the upstream layer may start its next inference immediately.

Parameters:
- numNeuron, 30, number of neurons in the upstream layer (words per frame); must be >= 2.
- dataWidth, 16, width of one activation word; matches the neuron dataWidth.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- neuron_out  input  numNeuron*dataWidth  concatenated neuron outputs; neuron i occupies bits [i*dataWidth +: dataWidth].
- neuron_valid  input  numNeuron  per-neuron outvalid bits.
- out_data  output  dataWidth  serial word; drives the next layer's myinput.
- out_valid  output  1  drives the next layer's myinputValid.
- frame_done  output  1  one-cycle pulse on the cycle that the last word of a frame is valid.
- busy  output  1  high while a frame is being emitted (state SHIFT).
- overrun  output  1  sticky error flag: a frame was dropped.
- misalign  output  1  sticky error flag: neuron_valid bits disagreed.

Behaviour:
- Reset (asynchronous, any time, including mid-frame) sets every output and register to zero:
  - out_data=0, out_valid=0, frame_done=0, busy=0, overrun=0, misalign=0;
  - state=IDLE, count=0, shift register=0.
- Capture event cap = neuron_valid[0]. Bit 0 is the reference bit.
- If cap=1 and neuron_valid is not all ones, set misalign=1 (sticky). The capture still proceeds.
- State IDLE, on cap:
  - load the shift register with neuron_out;
  - at the same edge, drive out_data <= word0, out_valid <= 1, count <= 1;
  - go to SHIFT.
  - Latency: the first word is valid exactly 1 cycle after the cycle in which neuron_valid is high.
- State SHIFT, each cycle:
  - out_data <= word[count], out_valid <= 1, count <= count+1.
  - Words leave in ascending neuron index, with no gaps.
- When the word at index numNeuron-1 is on out_data:
  - frame_done=1 in that same cycle;
  - at the next edge, out_valid <= 0, out_data <= 0, count <= 0, state <= IDLE.
- Back-to-back: cap in the cycle in which the word at index numNeuron-1 is being driven is accepted.
  - The shift register reloads.
  - word0 of the new frame follows the last word of the old frame at the next edge, with out_valid held continuously high.
  - busy stays high.
- cap in any other SHIFT cycle:
  - the new frame is dropped and overrun <= 1 (sticky);
  - the current frame continues unaffected.
- busy = (state==SHIFT), registered together with the state.
- Every frame is exactly numNeuron valid words. out_valid is never asserted for any other count.
- The block never applies backpressure; the downstream neuron consumes one word per valid cycle.
- overrun and misalign clear only on rst.
- Count width is $clog2(numNeuron+1).
- Data is passed bit-exact: no arithmetic and no width change.

Decomposition:
- Shared package (nn_pkg):
  - state enum {IDLE, SHIFT};
  - a function returning the counter width, $clog2(n+1).
- No sub-module is natural. One module: shift register, counter and 2-state FSM.

Test Plan:
- numNeuron=4, dataWidth=16; neuron_valid=4'hF for 1 cycle at cycle 10 with words 0x0001, 0x0002, 0x0003, 0x0004 -> out_valid high cycles 11-14, out_data 1,2,3,4 in order; frame_done only at cycle 14; busy high cycles 11-14; flags stay 0.
- Second cap at cycle 14 with words 0x0A..0x0D -> out_valid continuous cycles 11-18, out_data 1,2,3,4,A,B,C,D; overrun stays 0.
- Cap at cycle 12 during an active frame -> the original words 1-4 still emerge unaltered; overrun=1 from cycle 13 and stays 1 until rst.
- neuron_valid=4'b0111 at cycle 10 -> the frame is still emitted (4 words); misalign=1 from cycle 11, sticky.
- rst asserted asynchronously mid-cycle 12 -> all outputs 0 immediately, without waiting for a clock edge; after release, a new cap gives a clean 4-word frame.
- Changing neuron_out values during SHIFT -> no effect on the emitted words; the captured data is held.
